// File: rtl/ddr_mon_pkg.sv
// Shared types for the DDR4 command-bus monitor: command codes, record layout,
// sticky error flag bit positions and the command decoder.
package ddr_mon_pkg;

    localparam int unsigned MON_AWIDTH = 17;
    localparam int unsigned MON_BWIDTH = 2;
    localparam int unsigned MON_GWIDTH = 2;
    localparam int unsigned MON_RWIDTH = 1;

    localparam int unsigned FLAG_ACT_OPEN  = 0;
    localparam int unsigned FLAG_RW_CLOSED = 1;
    localparam int unsigned FLAG_REF_OPEN  = 2;
    localparam int unsigned FLAG_OVERFLOW  = 3;

    typedef enum logic [3:0] {
        CMD_ACT  = 4'd0,
        CMD_MRS  = 4'd1,
        CMD_REF  = 4'd2,
        CMD_PRE  = 4'd3,
        CMD_PREA = 4'd4,
        CMD_RFU  = 4'd5,
        CMD_WR   = 4'd6,
        CMD_WRA  = 4'd7,
        CMD_RD   = 4'd8,
        CMD_RDA  = 4'd9,
        CMD_ZQCS = 4'd10,
        CMD_ZQCL = 4'd11,
        CMD_NOP  = 4'd12
    } ddr_cmd_e;

    typedef struct packed {
        ddr_cmd_e                cmd;
        logic [MON_RWIDTH-1:0]   rank;
        logic [MON_GWIDTH-1:0]   bg;
        logic [MON_BWIDTH-1:0]   ba;
        logic [MON_AWIDTH-1:0]   row;
        logic [9:0]              col;
        logic                    ap;
        logic                    bc_n;
    } ddr_mon_rec_t;

    // rcw = {RAS_n, CAS_n, WE_n}
    function automatic ddr_cmd_e decode_cmd(input logic act_n, input logic [2:0] rcw, input logic ap);
        ddr_cmd_e c;
        if (!act_n) begin
            c = CMD_ACT;
        end else begin
            case (rcw)
                3'b000:  c = CMD_MRS;
                3'b001:  c = CMD_REF;
                3'b010:  c = ap ? CMD_PREA : CMD_PRE;
                3'b011:  c = CMD_RFU;
                3'b100:  c = ap ? CMD_WRA : CMD_WR;
                3'b101:  c = ap ? CMD_RDA : CMD_RD;
                3'b110:  c = ap ? CMD_ZQCL : CMD_ZQCS;
                default: c = CMD_NOP;
            endcase
        end
        return c;
    endfunction

endpackage

// File: rtl/ddr_mon_fifo.sv
// Show-ahead record FIFO; a push into a full FIFO is accepted only when a pop
// happens in the same cycle.
module ddr_mon_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter type         rec_t = logic [7:0]
) (
    input  logic clk,
    input  logic rst,
    input  logic push_i,
    input  rec_t push_data_i,
    output logic push_ok_o,
    output logic valid_o,
    input  logic ready_i,
    output rec_t data_o
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    rec_t          mem_q [DEPTH];
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [PW:0]   cnt_q, cnt_d;
    logic          full;
    logic          pop;

    assign full      = (cnt_q == (PW+1)'(DEPTH));
    assign valid_o   = (cnt_q != '0);
    assign pop       = valid_o & ready_i;
    assign push_ok_o = push_i & (~full | pop);
    assign data_o    = valid_o ? mem_q[rptr_q] : '0;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (push_ok_o) wptr_d = wptr_q + PW'(1);
        if (pop)       rptr_d = rptr_q + PW'(1);
        case ({push_ok_o, pop})
            2'b10:   cnt_d = cnt_q + (PW+1)'(1);
            2'b01:   cnt_d = cnt_q - (PW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok_o) mem_q[wptr_q] <= push_data_i;
    end

endmodule

// File: rtl/ddr_cmd_monitor.sv
// DDR4 command-bus monitor: registers the bus, decodes commands, tracks open
// banks per {rank,bg,ba}, flags protocol errors and queues command records.
module ddr_cmd_monitor
    import ddr_mon_pkg::*;
#(
    parameter int unsigned AWIDTH = 17,
    parameter int unsigned BWIDTH = 2,
    parameter int unsigned GWIDTH = 2,
    parameter int unsigned RWIDTH = 1,
    parameter int unsigned DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ddr4_reset_n,
    input  logic [RWIDTH-1:0] ddr4_cke,
    input  logic [RWIDTH-1:0] ddr4_cs_n,
    input  logic              ddr4_act_n,
    input  logic [GWIDTH-1:0] ddr4_bg,
    input  logic [BWIDTH-1:0] ddr4_ba,
    input  logic [AWIDTH-1:0] ddr4_addr,
    output logic              m_valid,
    input  logic              m_ready,
    output ddr_mon_rec_t      m_rec,
    output logic [3:0]        err_flags,
    output logic [31:0]       cmd_cnt,
    output logic [15:0]       drop_cnt
);

    localparam int unsigned BSHIFT = GWIDTH + BWIDTH;
    localparam int unsigned IW     = RWIDTH + BSHIFT;
    localparam int unsigned NB     = 1 << IW;

    logic              reset_n_q;
    logic [RWIDTH-1:0] cke_q, cs_n_q;
    logic              act_n_q;
    logic [GWIDTH-1:0] bg_q;
    logic [BWIDTH-1:0] ba_q;
    logic [AWIDTH-1:0] addr_q;

    logic [NB-1:0]     bank_open_q, bank_open_d;
    logic [AWIDTH-1:0] bank_row_q [NB];
    logic [3:0]        err_q, err_d, dec_flags;
    logic [31:0]       cmd_cnt_q, cmd_cnt_d;
    logic [15:0]       drop_cnt_q, drop_cnt_d;

    logic [RWIDTH-1:0] rank_sel;
    logic              rank_hit;
    logic              cmd_vld;
    logic [IW-1:0]     bank_idx;
    logic              cur_open;
    logic              rank_any_open;
    ddr_cmd_e          cmd;
    logic [AWIDTH-1:0] row_val;
    logic              row_we;
    logic              push, push_ok;
    ddr_mon_rec_t      rec;

    always_ff @(posedge clk) begin
        if (rst) begin
            reset_n_q <= '0;
            cke_q     <= '0;
            cs_n_q    <= '0;
            act_n_q   <= '0;
            bg_q      <= '0;
            ba_q      <= '0;
            addr_q    <= '0;
        end else begin
            reset_n_q <= ddr4_reset_n;
            cke_q     <= ddr4_cke;
            cs_n_q    <= ddr4_cs_n;
            act_n_q   <= ddr4_act_n;
            bg_q      <= ddr4_bg;
            ba_q      <= ddr4_ba;
            addr_q    <= ddr4_addr;
        end
    end

    // Lowest-index rank with cs_n low is the one addressed.
    always_comb begin
        rank_sel = '0;
        rank_hit = 1'b0;
        for (int unsigned i = 0; i < RWIDTH; i++) begin
            if (!rank_hit && !cs_n_q[i]) begin
                rank_sel = RWIDTH'(i);
                rank_hit = 1'b1;
            end
        end
    end

    assign cmd_vld  = reset_n_q & rank_hit & cke_q[rank_sel];
    assign bank_idx = {rank_sel, bg_q, ba_q};
    assign cur_open = bank_open_q[bank_idx];

    always_comb begin
        rank_any_open = 1'b0;
        for (int unsigned b = 0; b < NB; b++) begin
            if ((b >> BSHIFT) == 32'(rank_sel)) rank_any_open = rank_any_open | bank_open_q[IW'(b)];
        end
    end

    always_comb begin
        cmd         = CMD_NOP;
        row_val     = addr_q;
        row_we      = 1'b0;
        bank_open_d = bank_open_q;
        dec_flags   = err_q;
        if (!reset_n_q) begin
            bank_open_d = '0;
        end else if (cmd_vld) begin
            cmd = decode_cmd(act_n_q, addr_q[16:14], addr_q[10]);
            case (cmd)
                CMD_ACT: begin
                    if (cur_open) dec_flags[FLAG_ACT_OPEN] = 1'b1;
                    bank_open_d[bank_idx] = 1'b1;
                    row_we = 1'b1;
                end
                CMD_PRE: bank_open_d[bank_idx] = 1'b0;
                CMD_PREA: begin
                    for (int unsigned b = 0; b < NB; b++) begin
                        if ((b >> BSHIFT) == 32'(rank_sel)) bank_open_d[IW'(b)] = 1'b0;
                    end
                end
                CMD_REF: if (rank_any_open) dec_flags[FLAG_REF_OPEN] = 1'b1;
                CMD_RD, CMD_WR, CMD_RDA, CMD_WRA: begin
                    if (!cur_open) dec_flags[FLAG_RW_CLOSED] = 1'b1;
                    row_val = cur_open ? bank_row_q[bank_idx] : '0;
                    if (cmd == CMD_RDA || cmd == CMD_WRA) bank_open_d[bank_idx] = 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign push = (cmd != CMD_NOP);

    always_comb begin
        rec      = '0;
        rec.cmd  = cmd;
        rec.rank = MON_RWIDTH'(rank_sel);
        rec.bg   = MON_GWIDTH'(bg_q);
        rec.ba   = MON_BWIDTH'(ba_q);
        rec.row  = MON_AWIDTH'(row_val);
        rec.col  = addr_q[9:0];
        rec.ap   = addr_q[10];
        rec.bc_n = addr_q[12];
    end

    always_comb begin
        err_d      = dec_flags;
        drop_cnt_d = drop_cnt_q;
        cmd_cnt_d  = cmd_cnt_q + 32'(push_ok);
        if (push && !push_ok) begin
            err_d[FLAG_OVERFLOW] = 1'b1;
            if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bank_open_q <= '0;
            err_q       <= '0;
            cmd_cnt_q   <= '0;
            drop_cnt_q  <= '0;
        end else begin
            bank_open_q <= bank_open_d;
            err_q       <= err_d;
            cmd_cnt_q   <= cmd_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    // Rows need no reset: a row is only read while its open bit is set.
    always_ff @(posedge clk) begin
        if (row_we) bank_row_q[bank_idx] <= addr_q;
    end

    ddr_mon_fifo #(
        .DEPTH (DEPTH),
        .rec_t (ddr_mon_rec_t)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .push_data_i (rec),
        .push_ok_o   (push_ok),
        .valid_o     (m_valid),
        .ready_i     (m_ready),
        .data_o      (m_rec)
    );

    assign err_flags = err_q;
    assign cmd_cnt   = cmd_cnt_q;
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_ddr_cmd_monitor.sv
// Directed bench for ddr_cmd_monitor: a vector table of single commands plus
// hand-written overflow, full-with-pop and mid-stream reset sequences.
module tb_ddr_cmd_monitor;
    import ddr_mon_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic         ddr4_reset_n;
    logic [0:0]   ddr4_cke;
    logic [0:0]   ddr4_cs_n;
    logic         ddr4_act_n;
    logic [1:0]   ddr4_bg;
    logic [1:0]   ddr4_ba;
    logic [16:0]  ddr4_addr;
    logic         m_valid;
    logic         m_ready;
    ddr_mon_rec_t m_rec;
    logic [3:0]   err_flags;
    logic [31:0]  cmd_cnt;
    logic [15:0]  drop_cnt;

    int passed = 0;
    int total  = 0;

    ddr_cmd_monitor #(
        .AWIDTH (17),
        .BWIDTH (2),
        .GWIDTH (2),
        .RWIDTH (1),
        .DEPTH  (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ddr4_reset_n (ddr4_reset_n),
        .ddr4_cke     (ddr4_cke),
        .ddr4_cs_n    (ddr4_cs_n),
        .ddr4_act_n   (ddr4_act_n),
        .ddr4_bg      (ddr4_bg),
        .ddr4_ba      (ddr4_ba),
        .ddr4_addr    (ddr4_addr),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_rec        (m_rec),
        .err_flags    (err_flags),
        .cmd_cnt      (cmd_cnt),
        .drop_cnt     (drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rn;
        logic        cke;
        logic        cs_n;
        logic        act_n;
        logic [1:0]  bg;
        logic [1:0]  ba;
        logic [16:0] addr;
        logic        exp_v;
        ddr_cmd_e    exp_cmd;
        logic [16:0] exp_row;
        logic [3:0]  exp_flags;
    } vec_t;

    vec_t vecs [24];

    function automatic vec_t mk(logic rn, logic cke, logic cs_n, logic act_n,
                                logic [1:0] bg, logic [1:0] ba, logic [16:0] addr,
                                logic ev, ddr_cmd_e ec, logic [16:0] er, logic [3:0] ef);
        vec_t v;
        v.rn = rn; v.cke = cke; v.cs_n = cs_n; v.act_n = act_n;
        v.bg = bg; v.ba = ba; v.addr = addr;
        v.exp_v = ev; v.exp_cmd = ec; v.exp_row = er; v.exp_flags = ef;
        return v;
    endfunction

    function automatic ddr_mon_rec_t mk_rec(ddr_cmd_e c, logic [1:0] bg, logic [1:0] ba,
                                            logic [16:0] row, logic [16:0] addr);
        ddr_mon_rec_t r;
        r.cmd  = c;
        r.rank = 1'b0;
        r.bg   = bg;
        r.ba   = ba;
        r.row  = row;
        r.col  = addr[9:0];
        r.ap   = addr[10];
        r.bc_n = addr[12];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rn, input logic cke, input logic cs_n, input logic act_n,
                         input logic [1:0] bg, input logic [1:0] ba, input logic [16:0] addr);
        ddr4_reset_n = rn;
        ddr4_cke     = cke;
        ddr4_cs_n    = cs_n;
        ddr4_act_n   = act_n;
        ddr4_bg      = bg;
        ddr4_ba      = ba;
        ddr4_addr    = addr;
    endtask

    task automatic idle();
        drive(1'b1, 1'b1, 1'b1, 1'b1, 2'd0, 2'd0, 17'h1C000);
    endtask

    task automatic wr(input logic [1:0] bg, input logic [1:0] ba, input logic [9:0] col);
        drive(1'b1, 1'b1, 1'b0, 1'b1, bg, ba, 17'h11000 | 17'(col));
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else passed++;
    endtask

    initial begin
        int nrec;
        logic [9:0] exp_col [8];

        //              rn cke cs act bg    ba    addr       v  cmd       row        flags
        vecs[0]  = mk(1, 1, 0, 0, 2'd1, 2'd2, 17'h01234, 1, CMD_ACT,  17'h01234, 4'h0);
        vecs[1]  = mk(1, 1, 0, 1, 2'd1, 2'd2, 17'h153F8, 1, CMD_RD,   17'h01234, 4'h0);
        vecs[2]  = mk(1, 1, 0, 1, 2'd0, 2'd0, 17'h1D000, 0, CMD_NOP,  17'h00000, 4'h0);
        vecs[3]  = mk(1, 1, 1, 1, 2'd0, 2'd0, 17'h15001, 0, CMD_NOP,  17'h00000, 4'h0);
        vecs[4]  = mk(1, 0, 0, 1, 2'd0, 2'd0, 17'h15001, 0, CMD_NOP,  17'h00000, 4'h0);
        vecs[5]  = mk(1, 1, 0, 1, 2'd0, 2'd0, 17'h09400, 1, CMD_PREA, 17'h09400, 4'h0);
        vecs[6]  = mk(1, 1, 0, 1, 2'd0, 2'd0, 17'h05000, 1, CMD_REF,  17'h05000, 4'h0);
        vecs[7]  = mk(1, 1, 0, 1, 2'd0, 2'd0, 17'h15005, 1, CMD_RD,   17'h00000, 4'h2);
        vecs[8]  = mk(1, 1, 0, 0, 2'd0, 2'd0, 17'h000AB, 1, CMD_ACT,  17'h000AB, 4'h2);
        vecs[9]  = mk(1, 1, 0, 0, 2'd0, 2'd0, 17'h000CD, 1, CMD_ACT,  17'h000CD, 4'h3);
        vecs[10] = mk(1, 1, 0, 1, 2'd0, 2'd0, 17'h15410, 1, CMD_RDA,  17'h000CD, 4'h3);
        vecs[11] = mk(1, 1, 0, 1, 2'd0, 2'd0, 17'h11020, 1, CMD_WR,   17'h00000, 4'h3);
        vecs[12] = mk(1, 1, 0, 0, 2'd1, 2'd1, 17'h00777, 1, CMD_ACT,  17'h00777, 4'h3);
        vecs[13] = mk(1, 1, 0, 1, 2'd0, 2'd0, 17'h05000, 1, CMD_REF,  17'h05000, 4'h7);
        vecs[14] = mk(1, 1, 0, 1, 2'd1, 2'd1, 17'h11401, 1, CMD_WRA,  17'h00777, 4'h7);
        vecs[15] = mk(1, 1, 0, 1, 2'd1, 2'd1, 17'h11002, 1, CMD_WR,   17'h00000, 4'h7);
        vecs[16] = mk(1, 1, 0, 0, 2'd0, 2'd1, 17'h00055, 1, CMD_ACT,  17'h00055, 4'h7);
        vecs[17] = mk(0, 1, 0, 1, 2'd0, 2'd1, 17'h15003, 0, CMD_NOP,  17'h00000, 4'h7);
        vecs[18] = mk(1, 1, 0, 1, 2'd0, 2'd1, 17'h15004, 1, CMD_RD,   17'h00000, 4'h7);
        vecs[19] = mk(1, 1, 0, 1, 2'd0, 2'd1, 17'h09000, 1, CMD_PRE,  17'h09000, 4'h7);
        vecs[20] = mk(1, 1, 0, 1, 2'd0, 2'd0, 17'h01234, 1, CMD_MRS,  17'h01234, 4'h7);
        vecs[21] = mk(1, 1, 0, 1, 2'd0, 2'd0, 17'h19400, 1, CMD_ZQCL, 17'h19400, 4'h7);
        vecs[22] = mk(1, 1, 0, 1, 2'd0, 2'd0, 17'h0D000, 1, CMD_RFU,  17'h0D000, 4'h7);
        vecs[23] = mk(1, 1, 0, 1, 2'd0, 2'd0, 17'h19000, 1, CMD_ZQCS, 17'h19000, 4'h7);

        rst     = 1'b1;
        m_ready = 1'b0;
        idle();
        repeat (2) tick();
        rst = 1'b0;
        check("rst_valid", 64'(m_valid), 64'(0));
        check("rst_rec", 64'(m_rec), 64'(0));
        check("rst_flags", 64'(err_flags), 64'(0));
        check("rst_cmd_cnt", 64'(cmd_cnt), 64'(0));
        check("rst_drop_cnt", 64'(drop_cnt), 64'(0));

        // Each vector: drive for one cycle, one idle cycle, then the record is at the head.
        m_ready = 1'b1;
        nrec = 0;
        for (int i = 0; i < 24; i++) begin
            drive(vecs[i].rn, vecs[i].cke, vecs[i].cs_n, vecs[i].act_n,
                  vecs[i].bg, vecs[i].ba, vecs[i].addr);
            tick();
            idle();
            tick();
            check($sformatf("vec%0d_valid", i), 64'(m_valid), 64'(vecs[i].exp_v));
            if (vecs[i].exp_v) begin
                nrec++;
                check($sformatf("vec%0d_rec", i), 64'(m_rec),
                      64'(mk_rec(vecs[i].exp_cmd, vecs[i].bg, vecs[i].ba, vecs[i].exp_row, vecs[i].addr)));
            end
            check($sformatf("vec%0d_flags", i), 64'(err_flags), 64'(vecs[i].exp_flags));
        end
        tick();
        check("tbl_empty", 64'(m_valid), 64'(0));
        check("tbl_cmd_cnt", 64'(cmd_cnt), 64'(nrec));

        // Overflow: 10 writes into an 8-deep FIFO with the consumer stalled.
        m_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            wr(2'd0, 2'd0, 10'(i));
            tick();
        end
        idle();
        repeat (2) tick();
        check("ovf_valid", 64'(m_valid), 64'(1));
        check("ovf_drop_cnt", 64'(drop_cnt), 64'(2));
        check("ovf_flags", 64'(err_flags), 64'(4'hF));
        check("ovf_cmd_cnt", 64'(cmd_cnt), 64'(nrec + 8));
        m_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("ovf_drain%0d", i), 64'(m_rec),
                  64'(mk_rec(CMD_WR, 2'd0, 2'd0, 17'h0, 17'h11000 | 17'(i))));
            tick();
        end
        check("ovf_empty", 64'(m_valid), 64'(0));

        // Full FIFO with a pop in the same cycle as the push: push must be accepted.
        m_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            wr(2'd0, 2'd0, 10'h100 + 10'(i));
            tick();
            exp_col[i] = 10'h100 + 10'(i);
        end
        wr(2'd0, 2'd0, 10'h055);
        tick();
        m_ready = 1'b1;
        idle();
        tick();
        check("full_pop_drop_cnt", 64'(drop_cnt), 64'(2));
        check("full_pop_cmd_cnt", 64'(cmd_cnt), 64'(nrec + 17));
        for (int i = 0; i < 7; i++) exp_col[i] = exp_col[i+1];
        exp_col[7] = 10'h055;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("full_pop_drain%0d", i), 64'(m_valid ? m_rec.col : 10'h3FF), 64'(exp_col[i]));
            tick();
        end
        check("full_pop_empty", 64'(m_valid), 64'(0));

        // Reset mid-stream: 3 buffered records plus an ACT in flight.
        m_ready = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 2'd0, 17'h00321);
        tick();
        wr(2'd1, 2'd0, 10'd1);
        tick();
        wr(2'd1, 2'd0, 10'd2);
        tick();
        idle();
        tick();
        check("pre_rst_valid", 64'(m_valid), 64'(1));
        drive(1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 2'd0, 17'h000AA);
        tick();
        rst = 1'b1;
        idle();
        tick();
        rst = 1'b0;
        check("mid_rst_valid", 64'(m_valid), 64'(0));
        check("mid_rst_cmd_cnt", 64'(cmd_cnt), 64'(0));
        check("mid_rst_drop_cnt", 64'(drop_cnt), 64'(0));
        check("mid_rst_flags", 64'(err_flags), 64'(0));
        m_ready = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 1'b1, 2'd1, 2'd0, 17'h15007);
        tick();
        idle();
        tick();
        check("post_rst_valid", 64'(m_valid), 64'(1));
        check("post_rst_rec", 64'(m_rec), 64'(mk_rec(CMD_RD, 2'd1, 2'd0, 17'h0, 17'h15007)));
        check("post_rst_flags", 64'(err_flags), 64'(4'h2));
        check("post_rst_cmd_cnt", 64'(cmd_cnt), 64'(1));
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
